// File: rtl/instr_stream_encoder.sv
// Encodes symbolic KGP-RISC instructions into 32-bit words and streams them into instruction memory,
// holding the core in reset until loading completes. Define INSTR_NOP_FILL_EN to NOP-fill the unused tail.
module instr_stream_encoder #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [4:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err_op,
   output logic              err_full,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef INSTR_NOP_FILL_EN
   typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

   function automatic logic op_legal(input logic [4:0] op);
      return (op <= 5'd27);
   endfunction

   function automatic logic [31:0] encode(input logic [4:0] op, rs, rt, rd,
                                          input logic [15:0] imm);
      logic [5:0]  opc;
      logic [31:0] word;
      opc  = 6'd0;
      word = 32'd0;
      if (op <= 5'd9) begin
         word = {6'b000000, rs, rt, rd, 5'b00000, {1'b0, op} + 6'd1};
      end else begin
         if (op <= 5'd19)       opc = 6'b010000 + {1'b0, op - 5'd10};
         else if (op == 5'd20)  opc = 6'b011010;
         else if (op == 5'd21)  opc = 6'b100001;
         else if (op == 5'd22)  opc = 6'b100010;
         else if (op <= 5'd26)  opc = 6'b110000 + {1'b0, op - 5'd23};
         else                   opc = 6'b110100;
         // BR carries only the target register
         if (op == 5'd27) word = {opc, rs, 21'd0};
         else             word = {opc, rs, rt, imm};
      end
      return word;
   endfunction

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              accept, legal, at_end, restart;

   assign accept   = in_valid && in_ready;
   assign legal    = accept && op_legal(in_op);
   assign at_end   = (addr_q == LAST_ADDR);
   assign restart  = start && ((state_q == IDLE) || (state_q == DONE));
   assign cpu_hold = ~done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: begin
            if (legal && at_end) begin
               state_d = DONE;
            end else if (accept && in_last) begin
`ifdef INSTR_NOP_FILL_EN
               state_d = FILL;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef INSTR_NOP_FILL_EN
         FILL: if (at_end) state_d = DONE;
`endif
         DONE: if (start) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   // write port, session counters and status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE;
         imem_wdata <= 32'd0;
         addr_q     <= BASE;
         done       <= 1'b0;
         err_op     <= 1'b0;
         err_full   <= 1'b0;
         word_count <= '0;
      end else begin
         imem_we  <= 1'b0;
         in_ready <= (state_d == LOAD);
         // done lags entry into DONE so the final write is seen before the core is released
         done     <= (state_q == DONE) && (state_d == DONE);
         if (restart) begin
            addr_q     <= BASE;
            imem_addr  <= BASE;
            word_count <= '0;
            err_op     <= 1'b0;
            err_full   <= 1'b0;
         end else if ((state_q == LOAD) && accept) begin
            if (legal) begin
               imem_we    <= 1'b1;
               imem_addr  <= addr_q;
               imem_wdata <= encode(in_op, in_rs, in_rt, in_rd, in_imm);
               addr_q     <= addr_q + ADDR_W'(1);
               word_count <= word_count + (ADDR_W+1)'(1);
            end else begin
               err_op <= 1'b1;
            end
`ifdef INSTR_NOP_FILL_EN
         end else if (state_q == FILL) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr_q;
            imem_wdata <= 32'd0;
            addr_q     <= addr_q + ADDR_W'(1);
`endif
         end else if ((state_q == DONE) && in_valid) begin
            err_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: directed sessions plus randomized programs against a reference model.
`timescale 1ns/1ps
module tb_instr_stream_encoder;

   localparam int ADDR_W = 3;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int BASE   = 0;
`ifdef INSTR_NOP_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n, start, in_valid, in_ready, in_last;
   logic [4:0]        in_op, in_rs, in_rt, in_rd;
   logic [15:0]       in_imm;
   logic              imem_we, cpu_hold, done, err_op, err_full;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   word_count;

   instr_stream_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err_op(err_op), .err_full(err_full),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [ADDR_W+31:0] e;
   int m_addr, m_cnt, m_fills;
   bit m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference encoding straight from the op-code table
   function automatic logic [31:0] ref_enc(input int op, rs, rt, rd, imm);
      logic [31:0] r, t, d, i, o;
      r = 32'(rs); t = 32'(rt); d = 32'(rd); i = 32'(imm);
      if (op < 10) return (r << 21) | (t << 16) | (d << 11) | 32'(op + 1);
      if (op == 27) return (32'd52 << 26) | (r << 21);
      if (op < 20)       o = 32'(16 + op - 10);
      else if (op == 20) o = 32'd26;
      else if (op == 21) o = 32'd33;
      else if (op == 22) o = 32'd34;
      else               o = 32'(48 + op - 23);
      return (o << 26) | (r << 21) | (t << 16) | i;
   endfunction

   task automatic model_accept(input int op, input bit last, input logic [31:0] word);
      if (op <= 27) begin
         exp_q.push_back({ADDR_W'(m_addr), word});
         m_addr++;
         m_cnt++;
      end else begin
         m_err = 1'b1;
      end
      m_fills = 0;
      if (last && FILL_EN && m_addr < DEPTH) begin
         m_fills = DEPTH - m_addr;
         for (int a = m_addr; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), 32'h0});
      end
   endtask

   // called just after a falling edge; returns just after the falling edge following the handshake
   task automatic send(input int op, rs, rt, rd, imm, input bit last, input logic [31:0] word);
      bit hs;
      in_valid = 1'b1;
      in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm);
      in_last = last;
      hs = 1'b0;
      for (int w = 0; w < 10 && !hs; w++) begin
         hs = in_ready;
         @(posedge clk);
         if (hs) model_accept(op, last, word);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("handshake", 32'(hs), 32'd1);
   endtask

   task automatic send_rand(input int op, input bit last);
      int rs, rt, rd, imm;
      rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
      rd = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
      send(op, rs, rt, rd, imm, last, ref_enc(op, rs, rt, rd, imm));
   endtask

   task automatic start_session();
      start = 1'b1;
      @(posedge clk);
      m_addr = BASE; m_cnt = 0; m_err = 1'b0; m_fills = 0;
      @(negedge clk);
      start = 1'b0;
      check("start_ready", 32'(in_ready), 32'd1);
      check("start_hold", 32'(cpu_hold), 32'd1);
      check("start_done", 32'(done), 32'd0);
      check("start_err_op", 32'(err_op), 32'd0);
      check("start_err_full", 32'(err_full), 32'd0);
      check("start_count", 32'(word_count), 32'd0);
   endtask

   task automatic expect_end();
      int cyc;
      check("ready_low_at_end", 32'(in_ready), 32'd0);
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("done_latency", 32'(cyc), 32'(2 + m_fills));
      check("done", 32'(done), 32'd1);
      check("cpu_hold_released", 32'(cpu_hold), 32'd0);
      check("word_count", 32'(word_count), 32'(m_cnt));
      check("err_op", 32'(err_op), 32'(m_err));
      check("err_full", 32'(err_full), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'(BASE));
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err_op", 32'(err_op), 32'd0);
      check("rst_err_full", 32'(err_full), 32'd0);
      check("rst_count", 32'(word_count), 32'd0);
   endtask

   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0d data %h, no write expected", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(imem_addr), 32'(e[ADDR_W+31:32]));
            check("write_data", imem_wdata, e[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
      m_addr = BASE; m_cnt = 0; m_err = 1'b0; m_fills = 0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs();

      // single ADD
      start_session();
      send(0, 1, 2, 3, 0, 1'b1, 32'h00221801);
      expect_end();

      // back-to-back ADDI, LD, BR
      start_session();
      send(10, 4, 5, 0, 16'h0010, 1'b0, 32'h40850010);
      send(21, 0, 6, 0, 8, 1'b0, 32'h84060008);
      send(27, 7, 0, 0, 0, 1'b1, 32'hD0E00000);
      expect_end();

      // illegal op between two ADDs
      start_session();
      send(0, 1, 2, 3, 0, 1'b0, 32'h00221801);
      send(30, 1, 1, 1, 1, 1'b0, 32'h0);
      send(0, 0, 0, 0, 0, 1'b1, 32'h00000001);
      expect_end();

      // illegal op carrying in_last still ends the session
      start_session();
      send_rand($urandom_range(0, 27), 1'b0);
      send(29, 2, 3, 4, 5, 1'b1, 32'h0);
      expect_end();

      // start during LOAD is ignored: address keeps counting
      start_session();
      send_rand(1, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ready_after_ignored_start", 32'(in_ready), 32'd1);
      send_rand(20, 1'b1);
      expect_end();

      // fill memory completely, then an extra in_valid in DONE
      start_session();
      for (int k = 0; k < DEPTH; k++) send_rand($urandom_range(0, 27), 1'b0);
      expect_end();
      in_valid = 1'b1;
      in_op = 5'd0;
      @(negedge clk);
      in_valid = 1'b0;
      check("err_full_set", 32'(err_full), 32'd1);
      check("count_after_full", 32'(word_count), 32'(DEPTH));

      // randomized programs
      for (int s = 0; s < 12; s++) begin
         int n;
         n = $urandom_range(1, 6);
         start_session();
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_rand($urandom_range(0, 31), k == n - 1);
         end
         expect_end();
      end

      // reset in the middle of a session, then resume from the base address
      start_session();
      for (int k = 0; k < 3; k++) send_rand($urandom_range(0, 27), 1'b0);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs();
      check("queue_at_reset", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start_session();
      send_rand($urandom_range(0, 27), 1'b0);
      send_rand($urandom_range(0, 27), 1'b1);
      expect_end();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Program loader on the instruction-memory side of the pipelined KGP-RISC core. Accepts symbolic instructions (op select plus register/immediate fields) over a valid/ready handshake, encodes each into the 32-bit KGP-RISC word that the core's instruction decoder consumes, and writes the words sequentially into instruction memory. Holds the core in reset (`cpu_hold`) from `start` until loading completes.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width; capacity `DEPTH = 2**ADDR_W` words.
- `BASE_ADDR`, 0, first word address written after `start`.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load session (ignored unless IDLE or DONE).
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  encoder can accept this cycle.
- `in_last`  in  1  qualifies final instruction of the program.
- `in_op`  in  5  op select (codes below).
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_imm`  in  16  immediate / branch offset.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  32  encoded word.
- `cpu_hold`  out  1  keeps core in reset while high.
- `done`  out  1  load session complete (level).
- `err_op`  out  1  sticky: illegal `in_op` received.
- `err_full`  out  1  sticky: accepted input after memory full.
- `word_count`  out  ADDR_W+1  instructions written this session (excludes fill).

## Operation
- Op codes: 0–9 ADD,SUB,AND,OR,XOR,NOT,SLA,SLL,SRA,SRL; 10–19 same with I suffix; 20 MOVE; 21 LD; 22 ST; 23 BLT; 24 BGT; 25 BEQ; 26 BNE; 27 BR; 28–31 illegal.
- R-type (0–9): [31:26]=000000, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=0, [5:0]=in_op+1.
- I-type (10–19): [31:26]=010000+(in_op−10); MOVE: 011010. Fields rs, rt, imm[15:0].
- LD 100001, ST 100010, BLT..BNE 110000..110011, BR 110100; same rs/rt/imm layout; BR uses rs only, other fields zero.
- Encoded word is never 32'h0 (all-zero is the core's NOP).
- FSM: IDLE → (start) LOAD → (accepted in_last) FILL/DONE; LOAD → (address exhausted) DONE; DONE → (start) LOAD.
- IDLE: in_ready=0, cpu_hold=1. LOAD: in_ready=1 while words remain. DONE: cpu_hold=0, done=1.
- `start` clears word_count, err flags, done; loads address to BASE_ADDR.
- Illegal op: handshake completes, no write, address not advanced, err_op set; in_last on illegal op still ends session.
- Full: after write to address DEPTH−1, in_ready drops, FSM → DONE; any in_valid seen in DONE sets err_full.
- Address wraps modulo DEPTH only via BASE_ADDR≠0; session capacity is DEPTH−BASE_ADDR words.

## Timing
- Reset: state IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, err_op=0, err_full=0, word_count=0.
- Write latency 1: handshake at edge N → imem_we/addr/wdata registered valid for cycle N+1, single cycle.
- Throughput one instruction per cycle; no bubbles in LOAD.
- in_ready registered; goes low the cycle after last accepted or full.
- `done` and cpu_hold release assert the cycle after the final write (or last fill write).
- reset_n asserted mid-session: immediate return to reset values; partial memory contents undefined.
- start during LOAD/FILL ignored.

## Configuration
- `INSTR_NOP_FILL_EN` defined: after in_last, FILL state writes 32'h0 to every remaining address up to DEPTH−1, one per cycle, then DONE.
- Undefined: FILL state absent; in_last goes directly to DONE; remaining memory untouched.

## Test plan
- Reset, start, send ADD rs=1 rt=2 rd=3 last → one write at addr 0, wdata 32'h00221801, done next cycle, cpu_hold=0.
- Stream ADDI rs=4 rt=5 imm=16'h0010, LD rs=0 rt=6 imm=8, BR rs=7 last back-to-back → wdata 40850010, 84060008, D0E00000 on consecutive cycles, word_count=3.
- Send op=30 between two ADDs → err_op=1, only 2 writes at addr 0,1.
- ADDR_W=2: send 5 valid ops → 4 writes, DONE after 4th, fifth in_valid sets err_full.
- `INSTR_NOP_FILL_EN`, ADDR_W=3: one instruction last → 7 writes of 32'h0 at addr 1–7 then done.
- reset_n low during 3rd of 5 writes → outputs at reset values next edge; new start resumes from BASE_ADDR.
